sdp_bram_be: RTL and testbench

Parametrised simple dual-port block RAM with per-byte write enables, selectable read latency, defined same-address collision behaviour and a hardware clear sequencer that zeroes the array after reset. Port A writes and port B reads, both in the single `clka` domain. It is the general-purpose on-chip storage cell for core-side buffers (register-file shadows, I/D-cache data ways, DMA staging), and it maps onto Xilinx BRAM primitives.

---
 rtl/sdp_bram_be.sv | 82 ++++++++
 tb/tb_sdp_bram_be.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sdp_bram_be.sv
// sdp_bram_be: simple dual-port byte-enable block RAM with selectable read latency,
// same-address collision mode and a post-reset clear sequencer.
module sdp_bram_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clka,
  input  logic                    rst_n,
  output logic                    init_busy,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  input  logic                    enb,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    doutb_valid
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {CLEAR, READY} state_e;
  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    clr_wr, wr_acc, rd_acc, s1_v_q, s2_v_q;
  logic [NB-1:0]           be;
  logic [ADDR_WIDTH-1:0]   wa;
  logic [DATA_WIDTH-1:0]   wd, rd_d, s1_q, s2_q;

  generate
    if (DATA_WIDTH % 8 != 0 || (READ_LATENCY != 1 && READ_LATENCY != 2)) begin : g_bad
      $error("sdp_bram_be: illegal DATA_WIDTH or READ_LATENCY");
    end
  endgenerate

  // The clear sequencer shares the single write port, so port A is locked out while it runs.
  assign clr_wr      = rst_n && state_q == CLEAR;
  assign wr_acc      = rst_n && state_q == READY && ena;
  assign rd_acc      = rst_n && state_q == READY && enb;
  assign be          = clr_wr ? '1 : wr_acc ? wea : '0;
  assign wa          = clr_wr ? ptr_q : addra;
  assign wd          = clr_wr ? '0 : dina;
  assign init_busy   = state_q == CLEAR;
  assign doutb       = READ_LATENCY == 2 ? s2_q : s1_q;
  assign doutb_valid = READ_LATENCY == 2 ? s2_v_q : s1_v_q;

  // Write-through mode forwards the enabled lanes of a same-address write into the read data.
  always_comb begin
    rd_d = mem[addrb];
    for (int i = 0; i < NB; i++)
      rd_d[8*i +: 8] = (COLLISION_MODE == 1 && wr_acc && addra == addrb && wea[i]) ? dina[8*i +: 8] : rd_d[8*i +: 8];
  end

  always_ff @(posedge clka)
    for (int i = 0; i < NB; i++)
      if (be[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];

  always_ff @(posedge clka)
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
      ptr_q   <= '0;
    end else if (state_q == CLEAR) begin
      ptr_q <= ptr_q + 1'b1;
      if (&ptr_q) state_q <= READY;
    end

  always_ff @(posedge clka)
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_q   <= '0;
      s2_v_q <= 1'b0;
      s2_q   <= '0;
    end else begin
      s1_v_q <= rd_acc;
      if (rd_acc) s1_q <= rd_d;
      s2_v_q <= s1_v_q;
      if (s1_v_q) s2_q <= s1_q;
    end
endmodule

// File: tb/tb_sdp_bram_be.sv
// tb_sdp_bram_be: three configurations share one randomized stimulus stream; a reference
// model pushes expected reads into per-instance queues that a negedge monitor drains.
module tb_sdp_bram_be;
  localparam int N = 3;
  localparam int DEPTH = 1024;
  localparam int LAT  [N] = '{1, 2, 1};
  localparam int MODE [N] = '{0, 1, 0};
  localparam int CLR  [N] = '{1, 1, 0};

  typedef struct {
    logic [31:0] d;
    bit          known;
    int          due;
  } exp_t;

  logic        clka = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0;
  logic [9:0]  addra = '0, addrb = '0;
  logic [31:0] dina = '0;
  logic [31:0] doutb [N];
  logic        vld [N];
  logic        busy_o [N];

  logic [31:0] mm [N][DEPTH];
  bit          kn [N][DEPTH];
  int          busy [N];
  exp_t        q [N][$];
  int          cyc = 0;
  int          total = 0, passed = 0;

  always #5 clka = ~clka;
  always @(posedge clka) cyc <= cyc + 1;

  sdp_bram_be #(.READ_LATENCY(1), .COLLISION_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clka(clka), .rst_n(rst_n), .init_busy(busy_o[0]), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .doutb(doutb[0]), .doutb_valid(vld[0]));
  sdp_bram_be #(.READ_LATENCY(2), .COLLISION_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clka(clka), .rst_n(rst_n), .init_busy(busy_o[1]), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .doutb(doutb[1]), .doutb_valid(vld[1]));
  sdp_bram_be #(.READ_LATENCY(1), .COLLISION_MODE(0), .CLEAR_ON_RESET(0)) u2 (
    .clka(clka), .rst_n(rst_n), .init_busy(busy_o[2]), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .enb(enb), .addrb(addrb), .doutb(doutb[2]), .doutb_valid(vld[2]));

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    else passed++;
  endtask

  // Reference model: applies the upcoming edge's effect using the current inputs, then clocks.
  task automatic step();
    logic [31:0] old, mg;
    bit coll;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        busy[k] = CLR[k] ? DEPTH : 0;
        while (q[k].size() > 0 && q[k][q[k].size()-1].due >= cyc) void'(q[k].pop_back());
      end else if (busy[k] > 0) begin
        mm[k][DEPTH - busy[k]] = '0;
        kn[k][DEPTH - busy[k]] = 1'b1;
        busy[k]--;
      end else begin
        coll = ena && addra == addrb;
        if (enb) begin
          old = mm[k][addrb];
          mg  = old;
          for (int i = 0; i < 4; i++) if (coll && wea[i]) mg[8*i +: 8] = dina[8*i +: 8];
          q[k].push_back('{MODE[k] ? mg : old,
                           kn[k][addrb] || (MODE[k] == 1 && coll && wea == 4'hF),
                           cyc + LAT[k] - 1});
        end
        if (ena) begin
          for (int i = 0; i < 4; i++) if (wea[i]) mm[k][addra][8*i +: 8] = dina[8*i +: 8];
          if (wea == 4'hF) kn[k][addra] = 1'b1;
        end
      end
    end
    @(posedge clka);
    #1;
    for (int k = 0; k < N; k++) chk($sformatf("init_busy[%0d]", k), 32'(busy_o[k]), 32'(busy[k] > 0));
  endtask

  task automatic idle();
    ena = 0; enb = 0; wea = '0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] b);
    idle(); ena = 1; addra = a; dina = d; wea = b; step();
  endtask

  task automatic rd(input logic [9:0] a);
    idle(); enb = 1; addrb = a; step();
  endtask

  task automatic rnd(input int amax, input int n);
    for (int j = 0; j < n; j++) begin
      ena = 1'($urandom); enb = 1'($urandom); wea = 4'($urandom);
      addra = 10'($urandom_range(0, amax)); addrb = 10'($urandom_range(0, amax));
      dina = $urandom; step();
    end
    idle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    for (int j = 0; j < n; j++) begin
      ena = 1; enb = 1; wea = 4'hF; addra = 10'd900; addrb = 10'd900; dina = 32'hBAD0BAD0; step();
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_dout[%0d]", k), doutb[k], 32'h0);
      chk($sformatf("rst_valid[%0d]", k), 32'(vld[k]), 32'h0);
    end
    idle(); rst_n = 1;
  endtask

  always @(negedge clka)
    for (int k = 0; k < N; k++) begin
      exp_t x;
      if (vld[k] === 1'b1) begin
        if (q[k].size() == 0) begin
          total++;
          $display("FAIL unexpected_valid[%0d]: got valid with data %h expected no valid (cyc=%0d)", k, doutb[k], cyc);
        end else begin
          x = q[k].pop_front();
          chk($sformatf("read_timing[%0d]", k), 32'(cyc - 1), 32'(x.due));
          if (x.known) chk($sformatf("read_data[%0d]", k), doutb[k], x.d);
        end
      end else if (q[k].size() > 0 && q[k][0].due < cyc) begin
        x = q[k].pop_front();
        total++;
        $display("FAIL missing_valid[%0d]: got no valid expected data %h (cyc=%0d)", k, x.d, cyc);
      end
    end

  initial begin
    for (int k = 0; k < N; k++) for (int a = 0; a < DEPTH; a++) begin mm[k][a] = 'x; kn[k][a] = 0; end
    do_reset(2);
    wr(10'd1023, 32'h12345678, 4'hF);
    wr(10'd0, 32'h9, 4'hF);
    rd(10'd1023);
    rd(10'd0);
    rnd(1023, 1030);
    rd(10'd0); rd(10'd511); rd(10'd1023);
    wr(10'd5, 32'hAABBCCDD, 4'hF);
    wr(10'd5, 32'h11223344, 4'b0101);
    rd(10'd5);
    wr(10'd7, 32'h0, 4'hF);
    idle(); ena = 1; enb = 1; addra = 10'd7; addrb = 10'd7; dina = 32'hDEADBEEF; wea = 4'hF; step();
    rd(10'd7);
    for (int a = 0; a < 4; a++) wr(10'(a), 32'h10 + 32'(a), 4'hF);
    for (int a = 0; a < 4; a++) rd(10'(a));
    idle(); step(); step();
    wr(10'd1023, 32'h12345678, 4'hF);
    wr(10'd0, 32'h9, 4'hF);
    rd(10'd1023); rd(10'd0);
    wr(10'd900, 32'h55, 4'hF);
    rd(10'd900);
    do_reset(1);
    rnd(1023, 300);
    do_reset(1);
    rnd(1023, 1030);
    rd(10'd900);
    rnd(15, 1500);
    rnd(1023, 300);
    for (int j = 0; j < 5; j++) step();
    for (int k = 0; k < N; k++) chk($sformatf("drain[%0d]", k), 32'(q[k].size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
